// File: rtl/descrambler_64bit.sv
// descrambler_64bit
// Receive-side 64B/66B self-synchronizing descrambler, G(x) = 1 + x^39 + x^58,
// one 64-bit payload per clock plus the 2-bit sync header.
//
// Ports:
//   CLK          clock, all logic on posedge
//   RST          synchronous active-high reset
//   in_valid     data_in/hdr_in carry a block this cycle
//   hdr_in       sync header (01 data, 10 control, 00/11 invalid)
//   data_in      scrambled payload, bit 1 first on the wire
//   out_valid    registered copy of in_valid
//   hdr_out      hdr_in delayed one cycle, never scrambled
//   data_out     descrambled payload
//   seeded       data_out was computed from a fully primed state
//   clr_cnt      clears hdr_err_cnt (applied before any increment)
//   hdr_err_cnt  saturating count of invalid headers on valid blocks
module descrambler_64bit (
    input  logic         CLK,
    input  logic         RST,
    input  logic         in_valid,
    input  logic [1:0]   hdr_in,
    input  logic [64:1]  data_in,
    output logic         out_valid,
    output logic [1:0]   hdr_out,
    output logic [64:1]  data_out,
    output logic         seeded,
    input  logic         clr_cnt,
    output logic [7:0]   hdr_err_cnt
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned HDR_W  = 2;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned EXT_W  = 2 * DATA_W;
    localparam int unsigned TAP_A  = 39;
    localparam int unsigned TAP_B  = 58;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Scrambled payload of the most recent valid block; bits 1..6 are never tapped.
    logic [DATA_W:1]    prev;
    logic               primed;

    logic [EXT_W:1]     ext;
    logic [DATA_W:1]    descrambled;
    logic               hdr_bad;
    logic [CNT_W-1:0]   cnt_next;

    // Line-bit history x(k) lives at ext[DATA_W+k]: current block above, previous block below.
    assign ext = {data_in, prev};

    // Taps are always received bits, which is what makes the descrambler self-synchronizing.
    always_comb begin
        descrambled = '0;
        for (int i = 1; i <= int'(DATA_W); i++) begin
            descrambled[i] = data_in[i]
                           ^ ext[int'(DATA_W) + i - int'(TAP_A)]
                           ^ ext[int'(DATA_W) + i - int'(TAP_B)];
        end
    end

    // Both header bits equal means 00 or 11, neither of which is a legal sync header.
    assign hdr_bad = (hdr_in[1] == hdr_in[0]);

    // Clear first, then a saturating increment, so clear plus a bad header yields 1.
    always_comb begin
        cnt_next = clr_cnt ? '0 : hdr_err_cnt;
        if (in_valid && hdr_bad && (cnt_next != CNT_MAX)) begin
            cnt_next = cnt_next + CNT_W'(1);
        end
    end

    // Output and state registers; idle cycles hold everything but out_valid.
    always_ff @(posedge CLK) begin
        if (RST) begin
            prev        <= '0;
            primed      <= 1'b0;
            out_valid   <= 1'b0;
            hdr_out     <= HDR_W'(0);
            data_out    <= '0;
            seeded      <= 1'b0;
            hdr_err_cnt <= '0;
        end else begin
            out_valid   <= in_valid;
            hdr_err_cnt <= cnt_next;
            if (in_valid) begin
                prev     <= data_in;
                data_out <= descrambled;
                hdr_out  <= hdr_in;
                seeded   <= primed;
                primed   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_descrambler_64bit.sv
// Self-checking bench for descrambler_64bit: a transmit scrambler model feeds
// the DUT, expected blocks go into a scoreboard queue, a negedge monitor pops
// and compares them.
module tb_descrambler_64bit;

    logic         CLK = 1'b0;
    logic         RST;
    logic         in_valid;
    logic [1:0]   hdr_in;
    logic [64:1]  data_in;
    logic         out_valid;
    logic [1:0]   hdr_out;
    logic [64:1]  data_out;
    logic         seeded;
    logic         clr_cnt;
    logic [7:0]   hdr_err_cnt;

    descrambler_64bit dut (
        .CLK         (CLK),
        .RST         (RST),
        .in_valid    (in_valid),
        .hdr_in      (hdr_in),
        .data_in     (data_in),
        .out_valid   (out_valid),
        .hdr_out     (hdr_out),
        .data_out    (data_out),
        .seeded      (seeded),
        .clr_cnt     (clr_cnt),
        .hdr_err_cnt (hdr_err_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0]  hdr;
        logic [64:1] data;
        logic        chk;
        logic        seeded;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          tests = 0;
    int          fails = 0;
    logic [64:1] sc;          // scrambler history: last transmitted scrambled block
    logic        primed_m;
    int          cnt_m;
    logic [64:1] last_out;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [64:1] bit_m(input int k);
        logic [64:1] one;
        one = 64'(1);
        return one << (k - 1);
    endfunction

    // Transmit scrambler: output bits feed back, s[i] = d[i] ^ s(i-39) ^ s(i-58).
    task automatic scramble(input logic [64:1] d, output logic [64:1] s);
        logic a, b;
        s = '0;
        for (int i = 1; i <= 64; i++) begin
            a = (i >= 40) ? s[i-39] : sc[i+25];
            b = (i >= 59) ? s[i-58] : sc[i+6];
            s[i] = d[i] ^ a ^ b;
        end
        sc = s;
    endtask

    // Drive one valid block; line_flip corrupts the wire, exp_mask is the expected output damage.
    task automatic send(input logic [1:0] h, input logic [64:1] d, input logic [64:1] line_flip,
                        input logic [64:1] exp_mask, input logic chk, input logic clr);
        logic [64:1] s;
        scramble(d, s);
        in_valid = 1'b1;
        hdr_in   = h;
        data_in  = s ^ line_flip;
        clr_cnt  = clr;
        sb.push_back('{hdr: h, data: d ^ exp_mask, chk: chk, seeded: primed_m});
        primed_m = 1'b1;
        if (clr) cnt_m = 0;
        if ((h == 2'b00 || h == 2'b11) && cnt_m < 255) cnt_m++;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        clr_cnt  = 1'b0;
    endtask

    // Idle cycles: out_valid must drop and the payload must hold.
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b0;
            hdr_in   = 2'b00;
            @(posedge CLK);
            #1;
            check("idle_out_valid", 64'(out_valid), 64'(0));
            check("idle_hold", data_out, last_out);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge CLK) begin
        if (out_valid) begin
            last_out = data_out;
            if (sb.size() == 0) begin
                check("sb_underflow", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                check("hdr_out", 64'(hdr_out), 64'(e.hdr));
                check("seeded", 64'(seeded), 64'(e.seeded));
                if (e.chk) check("data_out", data_out, e.data);
            end
        end
    end

    initial begin
        logic [64:1] d;
        RST = 1'b1; in_valid = 1'b0; hdr_in = 2'b00; data_in = '0; clr_cnt = 1'b0;
        sc = '0; primed_m = 1'b0; cnt_m = 0; last_out = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_seeded", 64'(seeded), 64'(0));
        check("rst_hdr_out", 64'(hdr_out), 64'(0));
        check("rst_data_out", data_out, 64'(0));
        check("rst_cnt", 64'(hdr_err_cnt), 64'(0));
        RST = 1'b0;

        // Zero vectors: zero state scrambles zeros to zeros.
        for (int i = 0; i < 4; i++) send(2'b01, '0, '0, '0, 1'b1, 1'b0);

        // Round trip with a nonzero seed; the first block is unsynchronised.
        sc = {$urandom(), $urandom()} | 64'(1);
        for (int i = 0; i < 1000; i++) begin
            d = {$urandom(), $urandom()};
            send(($urandom_range(1) == 0) ? 2'b01 : 2'b10, d, '0, '0, i != 0, 1'b0);
            if ($urandom_range(3) == 0) idle(int'($urandom_range(2)) + 1);
        end

        // Error multiplication.
        send(2'b01, {$urandom(), $urandom()}, bit_m(1), bit_m(1) | bit_m(40) | bit_m(59), 1'b1, 1'b0);
        send(2'b01, {$urandom(), $urandom()}, '0, '0, 1'b1, 1'b0);
        send(2'b01, {$urandom(), $urandom()}, bit_m(30), bit_m(30), 1'b1, 1'b0);
        send(2'b10, {$urandom(), $urandom()}, '0, bit_m(5) | bit_m(24), 1'b1, 1'b0);
        send(2'b01, {$urandom(), $urandom()}, '0, '0, 1'b1, 1'b0);

        // Stall mid-stream.
        send(2'b01, {$urandom(), $urandom()}, '0, '0, 1'b1, 1'b0);
        idle(5);
        send(2'b10, {$urandom(), $urandom()}, '0, '0, 1'b1, 1'b0);
        send(2'b01, {$urandom(), $urandom()}, '0, '0, 1'b1, 1'b0);
        check("cnt_before_hdr_test", 64'(hdr_err_cnt), 64'(0));

        // Header errors: saturation, clear with error, ignored when idle.
        for (int i = 0; i < 300; i++) send(2'b11, {$urandom(), $urandom()}, '0, '0, 1'b1, 1'b0);
        check("cnt_saturate", 64'(hdr_err_cnt), 64'(255));
        check("cnt_model", 64'(hdr_err_cnt), 64'(cnt_m));
        send(2'b00, {$urandom(), $urandom()}, '0, '0, 1'b1, 1'b1);
        check("cnt_clr_plus_err", 64'(hdr_err_cnt), 64'(1));
        in_valid = 1'b0; hdr_in = 2'b00;
        @(posedge CLK);
        #1;
        check("cnt_idle_bad_hdr", 64'(hdr_err_cnt), 64'(1));

        // Reset mid-stream.
        send(2'b01, {$urandom(), $urandom()}, '0, '0, 1'b1, 1'b0);
        send(2'b10, {$urandom(), $urandom()}, '0, '0, 1'b1, 1'b0);
        RST = 1'b1; in_valid = 1'b1; hdr_in = 2'b11; data_in = {$urandom(), $urandom()}; clr_cnt = 1'b0;
        @(posedge CLK);
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'(0));
        check("mid_rst_seeded", 64'(seeded), 64'(0));
        check("mid_rst_hdr_out", 64'(hdr_out), 64'(0));
        check("mid_rst_data_out", data_out, 64'(0));
        check("mid_rst_cnt", 64'(hdr_err_cnt), 64'(0));
        RST = 1'b0; in_valid = 1'b0;
        sc = '0; primed_m = 1'b0; cnt_m = 0;
        for (int i = 0; i < 3; i++) send(2'b01, {$urandom(), $urandom()}, '0, '0, 1'b1, 1'b0);

        repeat (3) @(posedge CLK);
        #1;
        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
